fft_input_loader: RTL



---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_input_loader_if.sv | 23 ++
 rtl/fft_loader_half_ram.sv | 28 ++
 rtl/fft_input_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input loader: controller state encoding and
// the helper that derives the half-frame index width from the frame size.
package fft_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FILL_LO  = 3'd1,
      ST_FILL_HI  = 3'd2,
      ST_WAIT_RDY = 3'd3,
      ST_START    = 3'd4,
      ST_STREAM   = 3'd5
   } state_t;

   localparam int N_DEFAULT      = 1024;
   localparam int DATA_W_DEFAULT = 32;

   // Index width for one half-frame memory: $clog2(N/2), never below 1 bit.
   function automatic int addr_w(input int n);
      return (n >= 4) ? $clog2(n / 2) : 1;
   endfunction

   localparam int ADDR_W_DEFAULT = addr_w(N_DEFAULT);

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream into the loader: valid/ready handshake with a frame-end flag.
// Signal suffixes are seen from the loader side (_i into it, _o out of it).
interface fft_input_loader_if #(
   parameter int DATA_W = 32
);
   logic              s_valid_i;
   logic              s_ready_o;
   logic [DATA_W-1:0] s_re_i;
   logic [DATA_W-1:0] s_im_i;
   logic              s_last_i;

   // Producer of samples.
   modport master (
      output s_valid_i, s_re_i, s_im_i, s_last_i,
      input  s_ready_o
   );

   // The loader.
   modport slave (
      input  s_valid_i, s_re_i, s_im_i, s_last_i,
      output s_ready_o
   );
endinterface

// File: rtl/fft_loader_half_ram.sv
// Simple dual-port RAM holding one half of an FFT frame: one write port and a
// registered (one-cycle latency) read port, written to map onto block RAM.
module fft_loader_half_ram #(
   parameter int DEPTH  = 512,
   parameter int WIDTH  = 64,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Write port plus synchronous read of the addressed word every cycle.
   // NOTE: neither the array nor the read register has a reset, so the tools can
   // place this in block RAM; contents are meaningless until written anyway.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      o_rd_data <= r_mem[i_rd_addr];
   end

endmodule

// File: rtl/fft_input_loader.sv
// Frame loader in front of the radix-2 FFT engine. Buffers one N-point frame
// in two half-frame RAMs, then streams the butterfly pairs (x[k], x[k+N/2])
// to the engine, one pair per cycle, after a one-cycle start pulse.
module fft_input_loader
   import fft_pkg::*;
#(
   parameter int N      = 1024,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   fft_input_loader_if.slave s_if,
   input  logic              fft_ready_i,
   output logic              start_o,
   output logic              pair_valid_o,
   output logic [DATA_W-1:0] x0_re_o,
   output logic [DATA_W-1:0] x0_im_o,
   output logic [DATA_W-1:0] x1_re_o,
   output logic [DATA_W-1:0] x1_im_o,
   output logic              frame_err_o
);

   localparam int                HALF     = N / 2;
   localparam int                ADDR_W   = addr_w(N);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(HALF - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_wr_idx;
   logic [ADDR_W-1:0]   w_wr_idx_nxt;
   logic [ADDR_W-1:0]   r_rd_idx;
   logic [ADDR_W-1:0]   w_rd_idx_nxt;
   logic                r_s_ready;
   logic                r_start;
   logic                r_pair_valid;
   logic                r_frame_err;
   logic [DATA_W-1:0]   r_x0_re;
   logic [DATA_W-1:0]   r_x0_im;
   logic [DATA_W-1:0]   r_x1_re;
   logic [DATA_W-1:0]   r_x1_im;

   logic                w_hs;
   logic                w_err;
   logic                w_wr_lo;
   logic                w_wr_hi;
   logic                w_load;
   logic [2*DATA_W-1:0] w_wr_data;
   logic [2*DATA_W-1:0] w_lo_q;
   logic [2*DATA_W-1:0] w_hi_q;

   assign w_hs      = s_if.s_valid_i & r_s_ready;
   assign w_wr_data = {s_if.s_re_i, s_if.s_im_i};

   // Next-state, index and strobe decode for the fill / start / stream sequence.
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_wr_idx_nxt = r_wr_idx;
      w_rd_idx_nxt = '0;
      w_err        = 1'b0;
      w_wr_lo      = 1'b0;
      w_wr_hi      = 1'b0;
      w_load       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_FILL_LO;
         end

         ST_FILL_LO: begin
            if (w_hs) begin
               w_wr_lo = 1'b1;
               if (s_if.s_last_i) begin
                  // Frame end inside the first half: drop it and start over.
                  w_err        = 1'b1;
                  w_wr_idx_nxt = '0;
               end else if (r_wr_idx == LAST_IDX) begin
                  w_wr_idx_nxt = '0;
                  w_state_nxt  = ST_FILL_HI;
               end else begin
                  w_wr_idx_nxt = r_wr_idx + 1'b1;
               end
            end
         end

         ST_FILL_HI: begin
            if (w_hs) begin
               w_wr_hi = 1'b1;
               if (r_wr_idx == LAST_IDX) begin
                  // Sample N-1: a missing frame-end flag is flagged but the
                  // frame is still handed to the engine.
                  w_err        = ~s_if.s_last_i;
                  w_wr_idx_nxt = '0;
                  w_state_nxt  = ST_WAIT_RDY;
               end else if (s_if.s_last_i) begin
                  w_err        = 1'b1;
                  w_wr_idx_nxt = '0;
                  w_state_nxt  = ST_FILL_LO;
               end else begin
                  w_wr_idx_nxt = r_wr_idx + 1'b1;
               end
            end
         end

         ST_WAIT_RDY: begin
            if (fft_ready_i) begin
               w_state_nxt = ST_START;
            end
         end

         ST_START: begin
            // RAM already shows word 0 this cycle; fetch word 1 for the next.
            w_rd_idx_nxt = r_rd_idx + 1'b1;
            w_load       = 1'b1;
            w_state_nxt  = ST_STREAM;
         end

         ST_STREAM: begin
            // rd_idx runs one ahead of the pair on the outputs, so its wrap
            // back to 0 marks the cycle showing the final pair.
            w_rd_idx_nxt = r_rd_idx + 1'b1;
            if (r_rd_idx == '0) begin
               w_rd_idx_nxt = '0;
               w_state_nxt  = ST_FILL_LO;
            end else begin
               w_load = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, index counters and registered control outputs.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= ST_IDLE;
         r_wr_idx     <= '0;
         r_rd_idx     <= '0;
         r_s_ready    <= 1'b0;
         r_start      <= 1'b0;
         r_pair_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wr_idx     <= w_wr_idx_nxt;
         r_rd_idx     <= w_rd_idx_nxt;
         r_s_ready    <= (w_state_nxt == ST_FILL_LO) || (w_state_nxt == ST_FILL_HI);
         r_start      <= (w_state_nxt == ST_START);
         r_pair_valid <= w_load;
         r_frame_err  <= w_err;
      end
   end

   // Pair output registers: capture RAM read data while streaming, hold otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_x0_re <= '0;
         r_x0_im <= '0;
         r_x1_re <= '0;
         r_x1_im <= '0;
      end else if (w_load) begin
         r_x0_re <= w_lo_q[2*DATA_W-1:DATA_W];
         r_x0_im <= w_lo_q[DATA_W-1:0];
         r_x1_re <= w_hi_q[2*DATA_W-1:DATA_W];
         r_x1_im <= w_hi_q[DATA_W-1:0];
      end
   end

   // The read address is the next rd_idx, so RAM data in any cycle is the word
   // at the current rd_idx and pair k lands on the outputs in cycle START+1+k.
   fft_loader_half_ram #(
      .DEPTH  (HALF),
      .WIDTH  (2 * DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram_lo (
      .clk       (clk),
      .i_wr_en   (w_wr_lo),
      .i_wr_addr (r_wr_idx),
      .i_wr_data (w_wr_data),
      .i_rd_addr (w_rd_idx_nxt),
      .o_rd_data (w_lo_q)
   );

   fft_loader_half_ram #(
      .DEPTH  (HALF),
      .WIDTH  (2 * DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram_hi (
      .clk       (clk),
      .i_wr_en   (w_wr_hi),
      .i_wr_addr (r_wr_idx),
      .i_wr_data (w_wr_data),
      .i_rd_addr (w_rd_idx_nxt),
      .o_rd_data (w_hi_q)
   );

   assign s_if.s_ready_o = r_s_ready;
   assign start_o        = r_start;
   assign pair_valid_o   = r_pair_valid;
   assign frame_err_o    = r_frame_err;
   assign x0_re_o        = r_x0_re;
   assign x0_im_o        = r_x0_im;
   assign x1_re_o        = r_x1_re;
   assign x1_im_o        = r_x1_im;

endmodule
